// File: rtl/serial_stream_subtractor_if.sv
// rtl/serial_stream_subtractor_if.sv - serial operand stream in, parallel difference out
interface serial_stream_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             A;
    logic             B;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             valid;
    logic             busy;

    modport master (
        output start, A, B,
        input  diff_out, borrow_out, valid, busy
    );

    modport slave (
        input  start, A, B,
        output diff_out, borrow_out, valid, busy
    );
endinterface

// File: rtl/serial_stream_subtractor.sv
// rtl/serial_stream_subtractor.sv - bit-serial LSB-first subtractor with parallel result
module serial_stream_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_stream_subtractor_if.slave s
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx;
    logic             br;
    logic             br_in;
    logic             br_n;
    logic             d;
    logic             take;
    logic             last;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_n;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             valid_q;

    // In IDLE the bit on A/B is bit 0 of a new frame, so the index and borrow are forced to 0.
    always_comb begin
        take  = (state == RUN) || s.start;
        idx   = (state == RUN) ? cnt : '0;
        last  = take && (idx == CW'(WIDTH - 1));
        br_in = (state == RUN) && br;
        d     = s.A ^ s.B ^ br_in;
        br_n  = (~s.A & s.B) | (~(s.A ^ s.B) & br_in);
        sr_n  = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            sr_n[i] = sr[i+1];
        end
        sr_n[WIDTH-1] = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (s.start && !last) state_n = RUN;
            RUN:     if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        s.busy       = (state == RUN);
        s.valid      = valid_q;
        s.diff_out   = diff_q;
        s.borrow_out = borrow_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            br       <= 1'b0;
            sr       <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= take && last;
            if (take) begin
                sr  <= sr_n;
                br  <= last ? 1'b0 : br_n;
                cnt <= last ? '0 : idx + CW'(1);
            end
            if (take && last) begin
                diff_q   <= sr_n;
                borrow_q <= br_n;
            end
        end
    end
endmodule

// File: tb/tb_serial_stream_subtractor.sv
// tb/tb_serial_stream_subtractor.sv - directed checks of WIDTH=8 and WIDTH=1 instances
module tb_serial_stream_subtractor;
    logic clk;
    logic rst;
    int   tests_run;
    int   fails;

    serial_stream_subtractor_if #(.WIDTH(8)) if8 ();
    serial_stream_subtractor_if #(.WIDTH(1)) if1 ();

    serial_stream_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .s(if8.slave));
    serial_stream_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .s(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entered at a negedge; drives bits 0..7 and returns at the negedge after E7.
    task automatic frame8(input logic [7:0] a, input logic [7:0] b, input int restart_at);
        for (int k = 0; k < 8; k++) begin
            if8.start = (k == 0) || (k == restart_at);
            if8.A     = a[k];
            if8.B     = b[k];
            @(negedge clk);
            if (k < 7) begin
                tests_run++;
                if (if8.busy !== 1'b1 || if8.valid !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_busy bit%0d: busy=%b valid=%b, required busy=1 valid=0", k, if8.busy, if8.valid);
                end
            end
        end
        if8.start = 1'b0;
        if8.A     = 1'b0;
        if8.B     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if8.start = 0; if8.A = 0; if8.B = 0;
        if1.start = 0; if1.A = 0; if1.B = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if8.diff_out, if8.borrow_out, if8.valid, if8.busy} !== 11'h0) begin
            fails++;
            $display("FAIL reset8: diff=%h borrow=%b valid=%b busy=%b, required all 0", if8.diff_out, if8.borrow_out, if8.valid, if8.busy);
        end
        tests_run++;
        if ({if1.diff_out, if1.borrow_out, if1.valid, if1.busy} !== 4'h0) begin
            fails++;
            $display("FAIL reset1: diff=%b borrow=%b valid=%b busy=%b, required all 0", if1.diff_out, if1.borrow_out, if1.valid, if1.busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ignore;
        for (int k = 0; k < 4; k++) begin
            if8.A = k[0]; if8.B = ~k[0];
            @(negedge clk);
            tests_run++;
            if (if8.busy !== 1'b0 || if8.valid !== 1'b0 || if8.diff_out !== 8'h00) begin
                fails++;
                $display("FAIL idle_ignore: busy=%b valid=%b diff=%h, required 0/0/00", if8.busy, if8.valid, if8.diff_out);
            end
        end
        if8.A = 0; if8.B = 0;
    endtask

    task automatic test_basic;
        logic [7:0] av [3] = '{8'h25, 8'h00, 8'hFF};
        logic [7:0] bv [3] = '{8'h13, 8'h01, 8'hFF};
        logic [7:0] ev [3] = '{8'h12, 8'hFF, 8'h00};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            frame8(av[i], bv[i], -1);
            tests_run++;
            if (if8.valid !== 1'b1 || if8.busy !== 1'b0 || if8.diff_out !== ev[i] || if8.borrow_out !== eb[i]) begin
                fails++;
                $display("FAIL basic%0d: valid=%b busy=%b diff=%h borrow=%b, required 1/0/%h/%b", i, if8.valid, if8.busy, if8.diff_out, if8.borrow_out, ev[i], eb[i]);
            end
            @(negedge clk);
            tests_run++;
            if (if8.valid !== 1'b0 || if8.diff_out !== ev[i] || if8.borrow_out !== eb[i]) begin
                fails++;
                $display("FAIL basic_hold%0d: valid=%b diff=%h borrow=%b, required 0/%h/%b", i, if8.valid, if8.diff_out, if8.borrow_out, ev[i], eb[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        frame8(8'h80, 8'h01, -1);
        tests_run++;
        if (if8.valid !== 1'b1 || if8.diff_out !== 8'h7F || if8.borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first: valid=%b diff=%h borrow=%b, required 1/7f/0", if8.valid, if8.diff_out, if8.borrow_out);
        end
        frame8(8'h10, 8'h20, -1);
        tests_run++;
        if (if8.valid !== 1'b1 || if8.diff_out !== 8'hF0 || if8.borrow_out !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: valid=%b diff=%h borrow=%b, required 1/f0/1", if8.valid, if8.diff_out, if8.borrow_out);
        end
        // A frame right after a borrowing one must start with a clear borrow.
        frame8(8'h03, 8'h01, -1);
        tests_run++;
        if (if8.valid !== 1'b1 || if8.diff_out !== 8'h02 || if8.borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL b2b_third: valid=%b diff=%h borrow=%b, required 1/02/0", if8.valid, if8.diff_out, if8.borrow_out);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        frame8(8'h25, 8'h13, 3);
        tests_run++;
        if (if8.valid !== 1'b1 || if8.diff_out !== 8'h12 || if8.borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored: valid=%b diff=%h borrow=%b, required 1/12/0", if8.valid, if8.diff_out, if8.borrow_out);
        end
        @(negedge clk);
        tests_run++;
        if (if8.busy !== 1'b0 || if8.valid !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored_idle: busy=%b valid=%b, required 0/0", if8.busy, if8.valid);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] a = 8'h25;
        logic [7:0] b = 8'h13;
        for (int k = 0; k < 4; k++) begin
            if8.start = (k == 0); if8.A = a[k]; if8.B = b[k];
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({if8.diff_out, if8.borrow_out, if8.valid, if8.busy} !== 11'h0) begin
            fails++;
            $display("FAIL reset_mid: diff=%h borrow=%b valid=%b busy=%b, required all 0", if8.diff_out, if8.borrow_out, if8.valid, if8.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if8.start = 0; if8.A = a[k]; if8.B = b[k];
            @(negedge clk);
            tests_run++;
            if (if8.valid !== 1'b0 || if8.busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_valid cyc%0d: valid=%b busy=%b, required 0/0", k, if8.valid, if8.busy);
            end
        end
        frame8(8'h05, 8'h07, -1);
        tests_run++;
        if (if8.valid !== 1'b1 || if8.diff_out !== 8'hFE || if8.borrow_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_fresh: valid=%b diff=%h borrow=%b, required 1/fe/1", if8.valid, if8.diff_out, if8.borrow_out);
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        logic [1:0] av [3] = '{2'd0, 2'd1, 2'd1};
        logic [1:0] bv [3] = '{2'd1, 2'd0, 2'd1};
        logic       ed [3] = '{1'b1, 1'b1, 1'b0};
        logic       eb [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            if1.start = 1; if1.A = av[i][0]; if1.B = bv[i][0];
            @(negedge clk);
            tests_run++;
            if (if1.valid !== 1'b1 || if1.busy !== 1'b0 || if1.diff_out !== ed[i] || if1.borrow_out !== eb[i]) begin
                fails++;
                $display("FAIL width1_%0d: valid=%b busy=%b diff=%b borrow=%b, required 1/0/%b/%b", i, if1.valid, if1.busy, if1.diff_out, if1.borrow_out, ed[i], eb[i]);
            end
        end
        if1.start = 0; if1.A = 0; if1.B = 0;
        @(negedge clk);
        tests_run++;
        if (if1.valid !== 1'b0 || if1.busy !== 1'b0 || if1.diff_out !== 1'b0 || if1.borrow_out !== 1'b0) begin
            fails++;
            $display("FAIL width1_hold: valid=%b busy=%b diff=%b borrow=%b, required 0/0/0/0", if1.valid, if1.busy, if1.diff_out, if1.borrow_out);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst       = 1'b1;
        @(negedge clk);
        test_reset;
        test_idle_ignore;
        test_basic;
        test_back_to_back;
        test_start_ignored;
        test_reset_mid_frame;
        test_width1;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/serial_stream_subtractor.md
SERIAL_STREAM_SUBTRACTOR -- requirements
Module: serial_stream_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, frame length in bits; legal range WIDTH >= 1.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  frame marker; high in the cycle carrying bit 0 (LSB) of a frame.
REQ-005 A  input  1  minuend serial bit, LSB first.
REQ-006 B  input  1  subtrahend serial bit, LSB first.
REQ-007 diff_out  output  WIDTH  parallel difference A-B (mod 2^WIDTH) of the last completed frame.
REQ-008 borrow_out  output  1  final borrow of the last completed frame; 1 when A < B unsigned.
REQ-009 valid  output  1  one-cycle pulse: diff_out/borrow_out just updated.
REQ-010 busy  output  1  high while a frame is in progress after its first bit.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-012 Edge naming: E0 = rising edge at which start=1 is sampled in IDLE; Ek = k-th edge after E0.
REQ-013 In IDLE, start=1 SHALL begin a frame and sample A/B bit 0 at E0; start=0 SHALL leave all state unchanged.
REQ-014 Bit k of the frame SHALL be sampled at Ek, k = 0..WIDTH-1, one bit per cycle, no gaps.
REQ-015 Per bit: d = A^B^br; br_next = (~A&B) | (~(A^B)&br); br SHALL be 0 for bit 0 of every frame.
REQ-016 Difference bits SHALL be shifted into an internal WIDTH-bit register so that bit k lands at position k.
REQ-017 An internal bit counter SHALL track the sampled bit index and reset to 0 at the start of each frame.
REQ-018 At E(WIDTH-1), diff_out SHALL load the complete difference and borrow_out SHALL load br_next of bit WIDTH-1.
REQ-019 valid SHALL be 1 for exactly the cycle between E(WIDTH-1) and E(WIDTH); 0 otherwise.
REQ-020 Latency: result visible immediately after the edge sampling the last bit; no extra pipeline stage.
REQ-021 State SHALL be RUN from E0 to E(WIDTH-1) exclusive of the final edge; at E(WIDTH-1) it SHALL return to IDLE.
REQ-022 busy SHALL equal (state == RUN).
REQ-023 WIDTH=1: frame completes at E0; state never enters RUN; valid pulses after E0.
REQ-024 start while RUN SHALL be ignored; the bit on A/B is treated as the next data bit of the current frame.
REQ-025 start at E(WIDTH) (the cycle valid is high) SHALL begin a new frame: back-to-back frames, zero idle cycles.
REQ-026 Borrow SHALL NOT propagate between frames.
REQ-027 diff_out and borrow_out SHALL hold their values until the next frame completes.
REQ-028 A and B SHALL be ignored in IDLE when start=0.

Reset
REQ-029 While rst=1: diff_out=0, borrow_out=0, valid=0, busy=0, state=IDLE, counter=0, internal borrow=0, shift register=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no valid pulse; the first start after release begins a fresh frame.

Verification
REQ-031 WIDTH=8: start + A=0x25, B=0x13 serialized LSB first -> valid at E7, diff_out=0x12, borrow_out=0.
REQ-032 A=0x00, B=0x01 -> diff_out=0xFF, borrow_out=1; A=0xFF, B=0xFF -> diff_out=0x00, borrow_out=0.
REQ-033 Back-to-back: 0x80-0x01, then start at E8 with 0x10-0x20 -> first valid: 0x7F/0; second valid (8 cycles later): 0xF0/1; no borrow carry-over.
REQ-034 start re-asserted at E3 of a 0x25-0x13 frame -> ignored; result still 0x12/0 at E7; busy high E0..E7.
REQ-035 rst pulsed at E4 mid-frame -> outputs 0, no valid; subsequent frame 0x05-0x07 -> 0xFE, borrow_out=1.
REQ-036 WIDTH=1 instance: start, A=0, B=1 -> valid after E0, diff_out=1, borrow_out=1, busy stays 0.
